// File: rtl/ne_dot_pkg.sv
// ============================================================================
// Module      : ne_dot_pkg
// Description : Shared widths, scheduler state type and lane sign-extension
//               helper for the dot-product tree scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ne_dot_pkg;

    localparam int NE_NUM_LANES = 16;
    localparam int NE_LANE_W    = 31;
    localparam int NE_ACC_W     = 40;
    localparam int NE_CNT_W     = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } sched_state_e;

    function automatic logic [NE_ACC_W-1:0] sext_lane(input logic [NE_LANE_W-1:0] v);
        return {{(NE_ACC_W-NE_LANE_W){v[NE_LANE_W-1]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/DW02_tree_w31n16.sv
// ============================================================================
// Module      : DW02_tree_w31n16
// Description : 16-input, 31-bit carry-save reduction tree. OUT0 + OUT1
//               equals the sum of all inputs modulo 2^31.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module DW02_tree_w31n16 (
    input  logic [16*31-1:0] INPUT,
    output logic [30:0]      OUT0,
    output logic [30:0]      OUT1
);

    localparam int N = 16;
    localparam int W = 31;

    // Chain of 3:2 compressors; the carry vector is shifted left one place.
    always_comb begin
        logic [W-1:0] x;
        logic [W-1:0] ns;
        logic [W-1:0] nc;
        OUT0 = INPUT[0 +: W];
        OUT1 = INPUT[W +: W];
        x    = '0;
        ns   = '0;
        nc   = '0;
        for (int i = 2; i < N; i++) begin
            x    = INPUT[i*W +: W];
            ns   = OUT0 ^ OUT1 ^ x;
            nc   = ((OUT0 & OUT1) | (OUT0 & x) | (OUT1 & x)) << 1;
            OUT0 = ns;
            OUT1 = nc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ne_dot_tree_sched.sv
// ============================================================================
// Module      : ne_dot_tree_sched
// Description : Streams 16-lane product beats through the CSA tree, resolves
//               and accumulates per vector, returns one result per vector.
//               Optional macro NE_DOT_SAT_EN: saturating accumulate + out_sat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ne_dot_tree_sched
    import ne_dot_pkg::*;
#(
    parameter int NUM_LANES = NE_NUM_LANES,
    parameter int LANE_W    = NE_LANE_W,
    parameter int ACC_W     = NE_ACC_W,
    parameter int CNT_W     = NE_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES*LANE_W-1:0] in_data,
    input  logic [NUM_LANES-1:0]        in_mask,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_data,
    output logic [CNT_W-1:0]            out_beats,
    output logic                        busy
`ifdef NE_DOT_SAT_EN
    ,
    output logic                        out_sat
`endif
);

    sched_state_e                  r_state;
    sched_state_e                  w_state_nxt;
    logic                          w_stall;
    logic                          w_hs;
    logic                          w_s2_fire;
    logic [NUM_LANES*LANE_W-1:0]   w_tree_in;
    logic [LANE_W-1:0]             w_tree_sum;
    logic [LANE_W-1:0]             w_tree_carry;
    logic                          r_s1_valid;
    logic                          r_s1_first;
    logic                          r_s1_last;
    logic [LANE_W-1:0]             r_s1_sum;
    logic [LANE_W-1:0]             r_s1_carry;
    logic [LANE_W-1:0]             w_beat_raw;
    logic [ACC_W-1:0]              w_beat;
    logic [ACC_W-1:0]              w_acc_base;
    logic [ACC_W-1:0]              w_acc_nxt;
    logic [ACC_W-1:0]              r_acc;
    logic [CNT_W-1:0]              r_cnt;
    logic [CNT_W-1:0]              w_cnt_nxt;

    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~rst & ~w_stall;
    assign w_hs      = in_valid & in_ready;
    assign w_s2_fire = r_s1_valid & ~w_stall;
    assign busy      = (r_state != IDLE) | r_s1_valid;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_mask
        assign w_tree_in[gi*LANE_W +: LANE_W] = in_mask[gi] ? in_data[gi*LANE_W +: LANE_W] : '0;
    end

    DW02_tree_w31n16 u_tree (
        .INPUT (w_tree_in),
        .OUT0  (w_tree_sum),
        .OUT1  (w_tree_carry)
    );

    // Resolving the CSA pair modulo 2^LANE_W is the per-beat contribution.
    assign w_beat_raw = r_s1_sum + r_s1_carry;
    assign w_beat     = ACC_W'($signed(sext_lane(w_beat_raw)));
    assign w_acc_base = r_s1_first ? '0 : r_acc;
    assign w_cnt_nxt  = r_s1_first ? CNT_W'(1) :
                        (&r_cnt)   ? r_cnt     : r_cnt + CNT_W'(1);

`ifdef NE_DOT_SAT_EN
    logic [ACC_W:0] w_wide;
    logic           w_ovf;
    logic           r_sat;
    logic           w_sat_nxt;

    assign w_wide    = {w_acc_base[ACC_W-1], w_acc_base} + {w_beat[ACC_W-1], w_beat};
    assign w_ovf     = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_acc_nxt = !w_ovf        ? w_wide[ACC_W-1:0] :
                       w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                       {1'b0, {(ACC_W-1){1'b1}}};
    assign w_sat_nxt = (r_s1_first ? 1'b0 : r_sat) | w_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat   <= 1'b0;
            out_sat <= 1'b0;
        end else if (w_s2_fire) begin
            r_sat <= w_sat_nxt;
            if (r_s1_last) begin
                out_sat <= w_sat_nxt;
            end
        end
    end
`else
    assign w_acc_nxt = w_acc_base + w_beat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Framing only: the FSM remembers whether the next beat opens a vector.
    always_comb begin
        w_state_nxt = r_state;
        if (w_hs) begin
            case (r_state)
                IDLE:    if (!in_last) w_state_nxt = ACCUM;
                ACCUM:   if (in_last)  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_carry <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_beats  <= '0;
        end else begin
            if (!w_stall) begin
                r_s1_valid <= w_hs;
                if (w_hs) begin
                    r_s1_sum   <= w_tree_sum;
                    r_s1_carry <= w_tree_carry;
                    r_s1_first <= (r_state == IDLE);
                    r_s1_last  <= in_last;
                end
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A new result loaded on the consume edge keeps out_valid high.
            if (w_s2_fire) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                if (r_s1_last) begin
                    out_valid <= 1'b1;
                    out_data  <= w_acc_nxt;
                    out_beats <= w_cnt_nxt;
                end
            end
        end
    end

endmodule

`default_nettype wire
